// File: rtl/assist_pkg.sv
// Shared types and defaults for the pedal-assist level controller.
package assist_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        LOW  = 2'b01,
        MED  = 2'b10,
        HIGH = 2'b11
    } assist_lvl_t;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        LONG,
        REL_DB
    } press_state_t;

    localparam int unsigned TICK_CYC_DEF   = 50000;
    localparam int unsigned DB_TICKS_DEF   = 8;
    localparam int unsigned LONG_TICKS_DEF = 1000;
    localparam int unsigned RAMP_TICKS_DEF = 20;

    function automatic logic [2:0] lvl2scale(input assist_lvl_t lvl);
        logic [2:0] s;
        case (lvl)
            OFF:     s = 3'd0;
            LOW:     s = 3'd3;
            MED:     s = 3'd5;
            HIGH:    s = 3'd7;
            default: s = 3'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pb_press_fsm.sv
// Mode pushbutton: synchronizer, tick-based debounce and short/long
// press detection with registered one-cycle event pulses.
module pb_press_fsm
    import assist_pkg::*;
#(
    parameter int unsigned DB_TICKS   = DB_TICKS_DEF,
    parameter int unsigned LONG_TICKS = LONG_TICKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic btn_i,
    output logic short_evt_o,
    output logic long_evt_o
);

    localparam int unsigned CMAX =
        (LONG_TICKS > DB_TICKS) ? LONG_TICKS : DB_TICKS;
    localparam int unsigned CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_TICKS - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);

    if (DB_TICKS == 0) begin : g_bad_db
        $error("DB_TICKS must be at least 1");
    end
    if (LONG_TICKS == 0) begin : g_bad_long
        $error("LONG_TICKS must be at least 1");
    end

    logic [1:0]   sync_q;
    logic         btn;
    press_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         short_q, short_d;
    logic         long_q, long_d;

    assign btn = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn) begin
                    state_d = PRESS_DB;
                    cnt_d   = '0;
                end
            end
            PRESS_DB: begin
                if (!btn) begin
                    state_d = IDLE;
                end else if (tick_i) begin
                    if (cnt_q == DB_LAST) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HELD: begin
                if (!btn) begin
                    state_d = REL_DB;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end else if (tick_i) begin
                    if (cnt_q == LONG_LAST) begin
                        state_d = LONG;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LONG: begin
                if (!btn) begin
                    state_d = REL_DB;
                    cnt_d   = '0;
                end
            end
            REL_DB: begin
                // any bounce back to pressed restarts the release window
                if (btn) begin
                    cnt_d = '0;
                end else if (tick_i) begin
                    if (cnt_q == DB_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
        end
    end

    assign short_evt_o = short_q;
    assign long_evt_o  = long_q;

endmodule

// File: rtl/assist_lvl_ctrl.sv
// Pedal-assist level controller: tick timebase, level/enable, brake gating.
// Define ASSIST_RAMP_EN for slew-limited upward torque scale.
module assist_lvl_ctrl
    import assist_pkg::*;
#(
    parameter int unsigned TICK_CYC   = TICK_CYC_DEF,
    parameter int unsigned DB_TICKS   = DB_TICKS_DEF,
    parameter int unsigned LONG_TICKS = LONG_TICKS_DEF,
    parameter int unsigned RAMP_TICKS = RAMP_TICKS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tgglMd,
    input  logic       brake_n,
    output logic [1:0] setting,
    output logic       assist_en,
    output logic [2:0] scale,
    output logic       short_evt,
    output logic       long_evt
);

    localparam int unsigned TW = $clog2(TICK_CYC + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYC - 1);

    if (TICK_CYC == 0) begin : g_bad_tick
        $error("TICK_CYC must be at least 1");
    end
    if (RAMP_TICKS == 0) begin : g_bad_ramp
        $error("RAMP_TICKS must be at least 1");
    end

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tick;

    assign tick   = (tcnt_q == TICK_LAST);
    assign tcnt_d = tick ? '0 : tcnt_q + 1'b1;

    pb_press_fsm #(
        .DB_TICKS   (DB_TICKS),
        .LONG_TICKS (LONG_TICKS)
    ) u_press (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_i      (tick),
        .btn_i       (tgglMd),
        .short_evt_o (short_evt),
        .long_evt_o  (long_evt)
    );

    assist_lvl_t set_q, set_d;
    logic        en_q, en_d;
    logic [1:0]  brk_q;
    logic        braking;
    logic [2:0]  target;
    logic [2:0]  scale_q, scale_d;

    always_comb begin
        set_d = set_q;
        en_d  = en_q;
        if (short_evt) begin
            if (en_q) begin
                set_d = assist_lvl_t'(set_q + 2'd1);
            end else begin
                en_d = 1'b1;
            end
        end
        if (long_evt) begin
            en_d = ~en_q;
        end
    end

    assign braking = ~brk_q[1];
    assign target  = (en_q && !braking) ? lvl2scale(set_q) : 3'd0;

`ifdef ASSIST_RAMP_EN
    localparam int unsigned RW = $clog2(RAMP_TICKS + 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_TICKS - 1);

    logic [RW-1:0] ramp_q, ramp_d;

    // downward moves are immediate; only increases are paced by ticks
    always_comb begin
        scale_d = scale_q;
        ramp_d  = ramp_q;
        if (target <= scale_q) begin
            scale_d = target;
            ramp_d  = '0;
        end else if (tick) begin
            if (ramp_q == RAMP_LAST) begin
                scale_d = scale_q + 3'd1;
                ramp_d  = '0;
            end else begin
                ramp_d = ramp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_d;
        end
    end
`else
    assign scale_d = target;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q  <= '0;
            set_q   <= MED;
            en_q    <= 1'b1;
            brk_q   <= 2'b11;
            scale_q <= 3'd0;
        end else begin
            tcnt_q  <= tcnt_d;
            set_q   <= set_d;
            en_q    <= en_d;
            brk_q   <= {brk_q[0], brake_n};
            scale_q <= scale_d;
        end
    end

    assign setting   = set_q;
    assign assist_en = en_q;
    assign scale     = scale_q;

endmodule

// File: tb/tb_assist_lvl_ctrl.sv
// Self-checking bench for assist_lvl_ctrl with a behavioural level/scale model.
module tb_assist_lvl_ctrl;

    localparam int TICK = 4;
    localparam int DB   = 2;
    localparam int LONG = 10;
    localparam int RAMP = 3;

    logic       clk;
    logic       rst_n;
    logic       tgglMd;
    logic       brake_n;
    logic [1:0] setting;
    logic       assist_en;
    logic [2:0] scale;
    logic       short_evt;
    logic       long_evt;

    assist_lvl_ctrl #(
        .TICK_CYC   (TICK),
        .DB_TICKS   (DB),
        .LONG_TICKS (LONG),
        .RAMP_TICKS (RAMP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tgglMd    (tgglMd),
        .brake_n   (brake_n),
        .setting   (setting),
        .assist_en (assist_en),
        .scale     (scale),
        .short_evt (short_evt),
        .long_evt  (long_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: level, enable, brake and the level-to-torque table
    int m_set;
    bit m_en;
    bit m_brk;
    int lut [4] = '{0, 3, 5, 7};

    function automatic int m_target();
        return (m_en && !m_brk) ? lut[m_set] : 0;
    endfunction

    function automatic void m_short();
        if (m_en) m_set = (m_set + 1) % 4;
        else m_en = 1'b1;
    endfunction

    function automatic void m_long();
        m_en = !m_en;
    endfunction

    // monitor: event pulse counts and upward scale steps
    int         cyc = 0;
    int         ev_short = 0;
    int         ev_long = 0;
    int         step_t[$];
    logic [2:0] prev_scale = 3'd0;

    always @(negedge clk) begin
        cyc++;
        if (short_evt === 1'b1) ev_short++;
        if (long_evt === 1'b1) ev_long++;
        if (rst_n === 1'b1 && scale > prev_scale) begin
            step_t.push_back(cyc);
`ifdef ASSIST_RAMP_EN
            n_chk++;
            if (int'(scale) != int'(prev_scale) + 1)
                $display("FAIL ramp_step: got %0d want %0d", scale, prev_scale + 3'd1);
            else n_pass++;
`endif
        end
        prev_scale = scale;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_ticks(input int t);
        tgglMd = 1'b1;
        cycles(t * TICK);
        tgglMd = 1'b0;
        cycles((DB + 3) * TICK);
    endtask

    task automatic settle();
        cycles(8 * RAMP * TICK + 8);
    endtask

    task automatic test_reset();
        int r0;
        rst_n = 1'b0; tgglMd = 1'b0; brake_n = 1'b1;
        cycles(3);
        ev_short = 0; ev_long = 0;
        n_chk++; if (setting !== 2'd2) $display("FAIL rst_setting: got %0d want 2", setting); else n_pass++;
        n_chk++; if (assist_en !== 1'b1) $display("FAIL rst_en: got %0d want 1", assist_en); else n_pass++;
        n_chk++; if (scale !== 3'd0) $display("FAIL rst_scale: got %0d want 0", scale); else n_pass++;
        n_chk++; if (short_evt !== 1'b0) $display("FAIL rst_short: got %0d want 0", short_evt); else n_pass++;
        n_chk++; if (long_evt !== 1'b0) $display("FAIL rst_long: got %0d want 0", long_evt); else n_pass++;
        m_set = 2; m_en = 1'b1; m_brk = 1'b0;
        step_t.delete();
        r0 = cyc;
        rst_n = 1'b1;
`ifdef ASSIST_RAMP_EN
        cycles(8 * RAMP * TICK);
        n_chk++;
        if (step_t.size() != 5) begin
            $display("FAIL ramp_count: got %0d want 5", step_t.size());
        end else begin
            n_pass++;
            n_chk++;
            if (step_t[0] - r0 < (RAMP - 1) * TICK || step_t[0] - r0 > (RAMP + 1) * TICK + 1)
                $display("FAIL ramp_first: got %0d want %0d+-%0d", step_t[0] - r0, RAMP * TICK, TICK);
            else n_pass++;
            for (int i = 1; i < 5; i++) begin
                n_chk++;
                if (step_t[i] - step_t[i-1] != RAMP * TICK)
                    $display("FAIL ramp_interval%0d: got %0d want %0d", i, step_t[i] - step_t[i-1], RAMP * TICK);
                else n_pass++;
            end
        end
`else
        cycles(1);
        n_chk++; if (scale !== 3'd5) $display("FAIL rst_load: got %0d want 5", scale); else n_pass++;
`endif
        cycles(10);
        n_chk++; if (scale !== 3'(m_target())) $display("FAIL rst_hold: got %0d want %0d", scale, m_target()); else n_pass++;
        n_chk++; if (ev_short + ev_long != 0) $display("FAIL rst_noevt: got %0d want 0", ev_short + ev_long); else n_pass++;
    endtask

    task automatic test_short_press();
        bit found = 1'b0;
        ev_short = 0; ev_long = 0;
        tgglMd = 1'b1;
        cycles(5 * TICK);
        tgglMd = 1'b0;
        for (int i = 0; i < 10 * TICK; i++) begin
            cycles(1);
            if (short_evt === 1'b1) begin found = 1'b1; break; end
        end
        n_chk++;
        if (!found) begin
            $display("FAIL short_timeout: got none want short_evt");
        end else begin
            n_pass++;
            n_chk++; if (setting !== 2'(m_set)) $display("FAIL short_pre: got %0d want %0d", setting, m_set); else n_pass++;
            cycles(1);
            m_short();
            n_chk++; if (setting !== 2'(m_set)) $display("FAIL short_post: got %0d want %0d", setting, m_set); else n_pass++;
        end
        cycles((DB + 3) * TICK);
        n_chk++; if (ev_short != 1) $display("FAIL short_count: got %0d want 1", ev_short); else n_pass++;
        n_chk++; if (ev_long != 0) $display("FAIL short_nolong: got %0d want 0", ev_long); else n_pass++;
        settle();
        n_chk++; if (scale !== 3'(m_target())) $display("FAIL short_scale: got %0d want %0d", scale, m_target()); else n_pass++;
        ev_short = 0; ev_long = 0;
        press_ticks(1);
        n_chk++; if (ev_short + ev_long != 0) $display("FAIL glitch_evt: got %0d want 0", ev_short + ev_long); else n_pass++;
        n_chk++; if (setting !== 2'(m_set)) $display("FAIL glitch_set: got %0d want %0d", setting, m_set); else n_pass++;
    endtask

    task automatic test_level_cycle();
        for (int k = 0; k < 4; k++) begin
            press_ticks(4);
            m_short();
            n_chk++; if (setting !== 2'(m_set)) $display("FAIL cyc_set%0d: got %0d want %0d", k, setting, m_set); else n_pass++;
            settle();
            n_chk++; if (scale !== 3'(m_target())) $display("FAIL cyc_scale%0d: got %0d want %0d", k, scale, m_target()); else n_pass++;
        end
    endtask

    task automatic test_long_press();
        bit found = 1'b0;
        ev_short = 0; ev_long = 0;
        tgglMd = 1'b1;
        for (int i = 0; i < (DB + LONG + 4) * TICK; i++) begin
            cycles(1);
            if (long_evt === 1'b1) begin found = 1'b1; break; end
        end
        n_chk++;
        if (!found) begin
            $display("FAIL long_timeout: got none want long_evt");
        end else begin
            n_pass++;
            cycles(1);
            m_long();
            n_chk++; if (assist_en !== m_en) $display("FAIL long_en: got %0d want %0d", assist_en, m_en); else n_pass++;
            cycles(1);
            n_chk++; if (scale !== 3'(m_target())) $display("FAIL long_scale: got %0d want %0d", scale, m_target()); else n_pass++;
        end
        cycles(6 * TICK);
        tgglMd = 1'b0;
        cycles((DB + 3) * TICK);
        n_chk++; if (ev_long != 1) $display("FAIL long_count: got %0d want 1", ev_long); else n_pass++;
        n_chk++; if (ev_short != 0) $display("FAIL long_noshort: got %0d want 0", ev_short); else n_pass++;
        press_ticks(4);
        m_short();
        n_chk++; if (assist_en !== m_en) $display("FAIL reen_en: got %0d want %0d", assist_en, m_en); else n_pass++;
        n_chk++; if (setting !== 2'(m_set)) $display("FAIL reen_set: got %0d want %0d", setting, m_set); else n_pass++;
    endtask

    task automatic test_brake();
        settle();
        n_chk++; if (scale !== 3'(m_target())) $display("FAIL brk_pre: got %0d want %0d", scale, m_target()); else n_pass++;
        brake_n = 1'b0;
        cycles(2);
        n_chk++; if (scale !== 3'(m_target())) $display("FAIL brk_edge2: got %0d want %0d", scale, m_target()); else n_pass++;
        m_brk = 1'b1;
        cycles(1);
        n_chk++; if (scale !== 3'(m_target())) $display("FAIL brk_edge3: got %0d want %0d", scale, m_target()); else n_pass++;
        press_ticks(4);
        m_short();
        n_chk++; if (setting !== 2'(m_set)) $display("FAIL brk_set: got %0d want %0d", setting, m_set); else n_pass++;
        n_chk++; if (scale !== 3'(m_target())) $display("FAIL brk_scale: got %0d want %0d", scale, m_target()); else n_pass++;
        brake_n = 1'b1;
        m_brk = 1'b0;
        settle();
        n_chk++; if (scale !== 3'(m_target())) $display("FAIL brk_rel: got %0d want %0d", scale, m_target()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        press_ticks(4);
        m_short();
        tgglMd = 1'b1;
        cycles((DB + 2) * TICK);
        ev_short = 0; ev_long = 0;
        rst_n = 1'b0;
        #1;
        n_chk++; if (setting !== 2'd2) $display("FAIL mid_setting: got %0d want 2", setting); else n_pass++;
        n_chk++; if (assist_en !== 1'b1) $display("FAIL mid_en: got %0d want 1", assist_en); else n_pass++;
        n_chk++; if (scale !== 3'd0) $display("FAIL mid_scale: got %0d want 0", scale); else n_pass++;
        n_chk++; if (short_evt !== 1'b0 || long_evt !== 1'b0)
            $display("FAIL mid_evt: got %0d%0d want 00", short_evt, long_evt); else n_pass++;
        cycles(2);
        tgglMd = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        m_set = 2; m_en = 1'b1; m_brk = 1'b0;
        cycles((DB + 3) * TICK);
        n_chk++; if (ev_short + ev_long != 0) $display("FAIL mid_noevt: got %0d want 0", ev_short + ev_long); else n_pass++;
        settle();
        n_chk++; if (scale !== 3'(m_target())) $display("FAIL mid_ramp: got %0d want %0d", scale, m_target()); else n_pass++;
    endtask

    task automatic test_random();
        int kind, t, s0, l0;
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                brake_n = ~brake_n;
                m_brk = !brake_n;
                cycles(4);
            end
            kind = $urandom_range(0, 2);
            case (kind)
                0: t = 1;
                1: t = $urandom_range(DB + 1, DB + LONG - 2);
                default: t = $urandom_range(DB + LONG + 2, DB + LONG + 8);
            endcase
            s0 = ev_short; l0 = ev_long;
            press_ticks(t);
            if (kind == 1) m_short();
            if (kind == 2) m_long();
            n_chk++;
            if (ev_short - s0 != int'(kind == 1) || ev_long - l0 != int'(kind == 2))
                $display("FAIL rnd_evt%0d: got s%0d l%0d want s%0d l%0d (t=%0d)",
                         it, ev_short - s0, ev_long - l0, kind == 1, kind == 2, t);
            else n_pass++;
            n_chk++; if (setting !== 2'(m_set)) $display("FAIL rnd_set%0d: got %0d want %0d", it, setting, m_set); else n_pass++;
            n_chk++; if (assist_en !== m_en) $display("FAIL rnd_en%0d: got %0d want %0d", it, assist_en, m_en); else n_pass++;
            settle();
            n_chk++; if (scale !== 3'(m_target())) $display("FAIL rnd_scale%0d: got %0d want %0d", it, scale, m_target()); else n_pass++;
        end
        brake_n = 1'b1;
        m_brk = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        tgglMd = 1'b0;
        brake_n = 1'b1;
        test_reset();
        test_short_press();
        test_level_cycle();
        test_long_press();
        test_brake();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/assist_lvl_ctrl.md
# assist_lvl_ctrl

Pedal-assist level controller for the e-bike. Turns the raw mode pushbutton into debounced short-press and long-press events, sequences the assist level (OFF/LOW/MED/HIGH), and drives the torque scale to the motor-drive math. Scale is slew-limited upward, forced low on brake, and gated by an assist enable toggled with a long press.

## Interface
- TICK_CYC, 50000: clk cycles per timebase tick (1 ms at 50 MHz)
- DB_TICKS, 8: ticks of stable level needed to accept a press or release
- LONG_TICKS, 1000: ticks held, counted from the accepted press, that make a long press
- RAMP_TICKS, 20: ticks per +1 step of upward scale ramp
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tgglMd  in  1  raw pushbutton, asynchronous, 1 = pressed
- brake_n  in  1  brake lever, asynchronous, 0 = braking
- setting  out  2  assist level: 00 OFF, 01 LOW, 10 MED, 11 HIGH
- assist_en  out  1  assist enabled
- scale  out  3  torque scale applied to the drive
- short_evt  out  1  one-cycle pulse on an accepted short press
- long_evt  out  1  one-cycle pulse on an accepted long press

## Operation
- tgglMd and brake_n each pass through a 2-flop synchronizer, reset to 0 and 1.
- Tick: one-cycle pulse every TICK_CYC clk. All DB, LONG and RAMP counting advances on ticks only.
- Press FSM states: IDLE, PRESS_DB, HELD, LONG, REL_DB.
  - IDLE: btn=1 goes to PRESS_DB and clears the count.
  - PRESS_DB: btn=0 returns to IDLE. Count reaching DB_TICKS goes to HELD and clears the count.
  - HELD: btn=0 goes to REL_DB and pulses short_evt. Count reaching LONG_TICKS goes to LONG and pulses long_evt.
  - LONG: btn=0 goes to REL_DB. No further events, however long the hold.
  - REL_DB: btn=1 restarts the count. Count reaching DB_TICKS goes to IDLE.
- short_evt with assist_en=1: setting increments and wraps 11 to 00.
- short_evt with assist_en=0: sets assist_en=1; setting is unchanged.
- long_evt toggles assist_en.
- Target scale:
  - 0 when assist_en=0 or braking.
  - Otherwise a lookup on setting: 00→0, 01→3, 10→5, 11→7.
- scale behaviour:
  - Target below scale: scale loads target on the next clk, with no ramp.
  - Target above scale: scale steps +1 every RAMP_TICKS ticks until equal. The ramp tick counter clears whenever scale equals or exceeds the target.
- Simultaneous events:
  - Brake asserted during a ramp drops scale to 0, and the ramp restarts from 0 on release.
  - short_evt during brake still updates setting.
  - long_evt during brake still toggles assist_en.
- Reset values:
  - setting=10, assist_en=1, scale=0, short_evt=0, long_evt=0.
  - FSM=IDLE; all counters 0.
- Reset mid-operation aborts any press or ramp immediately. After release, scale ramps from 0.

## Timing
- Button input to FSM: 2 clk synchronizer latency.
- short_evt/long_evt are registered. setting/assist_en update 1 clk after the event.
- Brake: scale=0 on the 3rd clk edge after brake_n falls (2-flop sync plus the registered scale).
- Ramp 0→5 takes 5×RAMP_TICKS ticks (±1 tick phase).
- Minimum accepted press: DB_TICKS ticks of btn=1 (±1 tick phase).

## Configuration
- ASSIST_RAMP_EN defined: upward slew limiting as specified above.
- ASSIST_RAMP_EN undefined:
  - scale loads the target on the next clk in both directions.
  - The ramp counter and the RAMP_TICKS parameter are unused.
  - All other behaviour is identical.

## Structure
- Package assist_pkg:
  - assist_lvl_t enum (OFF, LOW, MED, HIGH).
  - press_state_t enum.
  - Function lvl2scale() with the lookup values.
  - Default tick constants.
- Sub-module pb_press_fsm: synchronizer, tick-driven debounce, press FSM, short_evt/long_evt.
- Top level: tick generator, level/enable registers, brake sync, scale ramp.

## Test plan
- Bench parameters TICK_CYC=4, DB_TICKS=2, LONG_TICKS=10, RAMP_TICKS=3.
- Reset release, no input: setting=10, assist_en=1, scale ramps 0→5 in +1 steps every 3 ticks, then holds 5.
- Press of 5 ticks then release: exactly one short_evt, setting 10→11, scale ramps 5→7. A 1-tick glitch gives no event.
- Four short presses from 11: setting goes 00, 01, 10, 11. Step to 00 sets scale 0 next clk; 01 ramps to 3.
- Hold 15 ticks: one long_evt, no short_evt, assist_en=0, scale=0 next clk. Next short press: assist_en=1, setting unchanged.
- brake_n low while scale=7: scale=0 by the 3rd clk edge. Short press during brake moves setting to 00. On release, scale stays 0.
- rst_n asserted mid-ramp and mid-press: all outputs return to reset values immediately, no event pulses.
